// File: rtl/mux_pair_sampler_pkg.sv
// Shared definitions for the mux pair sampler: FSM state encodings and counter width.
package mux_pair_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL_A = 2'd1,
    SEL_B = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mux_pair_sampler_capture.sv
// pair_capture_reg: two WIDTH-bit enable registers holding the lo (sel=0) and hi (sel=1) samples.
module pair_capture_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lo_en,
  input  logic             hi_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo <= '0;
      hi <= '0;
    end else begin
      if (lo_en) lo <= din;
      if (hi_en) hi <= din;
    end
  end

endmodule

// File: rtl/mux_pair_sampler.sv
// Drives the external 2:1 mux select, captures one sample per input and hands the
// pair downstream with valid/ready, PAIRS times per start, then pulses done.
module mux_pair_sampler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PAIRS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mux_out,
  output logic               sel,
  output logic [2*WIDTH-1:0] data_out,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               done
);

  import mux_pair_sampler_pkg::*;

  state_t           state, state_next;
  logic [CNT_W-1:0] pair_cnt;
  logic             lo_en, hi_en, accept, last;
  logic [WIDTH-1:0] lo, hi;

  assign accept = (state == OUT) && ready;
  assign last   = (pair_cnt == CNT_W'(PAIRS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEL_A;
      SEL_A:   state_next = SEL_B;
      SEL_B:   state_next = OUT;
      OUT:     if (accept) state_next = last ? IDLE : SEL_A;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel   = (state == SEL_B);
    lo_en = (state == SEL_A);
    hi_en = (state == SEL_B);
  end

  // Status flags are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pair_cnt <= '0;
    end else begin
      valid <= (state_next == OUT);
      busy  <= (state_next != IDLE);
      done  <= accept && last;
      if (accept) pair_cnt <= last ? '0 : pair_cnt + 1'b1;
    end
  end

  pair_capture_reg #(
    .WIDTH(WIDTH)
  ) u_capture (
    .clk   (clk),
    .reset (reset),
    .lo_en (lo_en),
    .hi_en (hi_en),
    .din   (mux_out),
    .lo    (lo),
    .hi    (hi)
  );

  assign data_out = {hi, lo};

endmodule

// File: tb/tb_mux_pair_sampler.sv
// Directed bench for mux_pair_sampler with a behavioural 2:1 mux on the select path.
module tb_mux_pair_sampler;

  logic       clk = 1'b1;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] mux_out;
  logic       sel;
  logic [7:0] data_out;
  logic       valid, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_out = sel ? b : a;

  mux_pair_sampler #(
    .WIDTH(4),
    .PAIRS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mux_out  (mux_out),
    .sel      (sel),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  // Steps negedges until done is seen; hs counts negedges with valid&ready (accepted at the next edge).
  task automatic run_to_done(input int max, output int cyc, output int hs);
    cyc = 0;
    hs  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (valid && ready) hs++;
    end while (!done && cyc < max);
  endtask

  int cyc, hs;

  initial begin
    // 1: reset state
    #15 reset = 1'b0;
    #1;
    chk("rst_sel",   32'(sel),      32'd0);
    chk("rst_valid", 32'(valid),    32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_data",  32'(data_out), 32'h00);

    // 2: basic run, ready tied high
    @(negedge clk);
    a = 4'b1010; b = 4'b0101; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s2_sel_a", 32'(sel),   32'd0);
    chk("s2_busy",  32'(busy),  32'd1);
    chk("s2_nval",  32'(valid), 32'd0);
    @(negedge clk);
    chk("s2_sel_b", 32'(sel), 32'd1);
    @(negedge clk);
    chk("s2_valid", 32'(valid),    32'd1);
    chk("s2_data",  32'(data_out), 32'h5A);
    run_to_done(30, cyc, hs);
    chk("s2_done_lat", 32'(cyc + 2), 32'd9);
    chk("s2_hs",       32'(hs + 1),  32'd3);
    @(negedge clk);
    chk("s2_done_pulse", 32'(done), 32'd0);
    chk("s2_idle",       32'(busy), 32'd0);

    // 3: backpressure holds data while mux inputs change
    a = 4'b0000; b = 4'b1111; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("s3_valid");
    chk("s3_data", 32'(data_out), 32'hF0);
    a = 4'b0011; b = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_hold_v", 32'(valid),    32'd1);
      chk("s3_hold_d", 32'(data_out), 32'hF0);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("s3_accept", 32'(valid), 32'd0);
    run_to_done(30, cyc, hs);
    chk("s3_hs",   32'(hs),       32'd2);
    chk("s3_keep", 32'(data_out), 32'h33);
    @(negedge clk);

    // 4: start held through the run, restart only from the done cycle
    a = 4'b0001; b = 4'b0010; ready = 1'b1; start = 1'b1;
    run_to_done(40, cyc, hs);
    chk("s4_hs",        32'(hs),   32'd3);
    chk("s4_len",       32'(cyc),  32'd10);
    chk("s4_done_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("s4_restart", 32'(busy), 32'd1);
    start = 1'b0;
    run_to_done(40, cyc, hs);
    chk("s4_hs2",  32'(hs),  32'd3);
    chk("s4_len2", 32'(cyc), 32'd9);
    @(negedge clk);

    // 5: asynchronous reset while valid
    a = 4'b0111; b = 4'b1000; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("s5_valid");
    reset = 1'b1;
    #1;
    chk("s5_valid_drop", 32'(valid),    32'd0);
    chk("s5_busy_drop",  32'(busy),     32'd0);
    chk("s5_sel",        32'(sel),      32'd0);
    chk("s5_data",       32'(data_out), 32'h00);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("s5_idle", 32'(busy), 32'd0);
    ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s5_busy", 32'(busy), 32'd1);
    run_to_done(30, cyc, hs);
    chk("s5_hs",     32'(hs),       32'd3);
    chk("s5_len",    32'(cyc),      32'd9);
    chk("s5_data2",  32'(data_out), 32'h87);
    @(negedge clk);

    // 6: b changes between the lo and hi captures
    a = 4'b0110; b = 4'b1001; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("s6_sel_b", 32'(sel), 32'd1);
    b = 4'b1100;
    @(negedge clk);
    chk("s6_valid", 32'(valid),    32'd1);
    chk("s6_data",  32'(data_out), 32'hC6);
    run_to_done(30, cyc, hs);
    chk("s6_hs", 32'(hs),   32'd2);
    chk("s6_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
